// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack for call/ret, plus sticky
// overflow/underflow flags. Commands are resolved by priority: ret > call > load > count.
module pc_stack #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    localparam int                   SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  count,
    input  logic                  load,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  clr_err,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [SPW-1:0]        sp,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int IDXW = $clog2(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]        sp_q, sp_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic                  push_en;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [SPW-1:0]        sp_m1;
    logic [IDXW-1:0]       push_idx;
    logic [IDXW-1:0]       pop_idx;
    logic                  full_w;
    logic                  empty_w;

    assign pc_inc   = pc_q + ADDR_WIDTH'(1);
    assign sp_m1    = sp_q - SPW'(1);
    assign push_idx = sp_q[IDXW-1:0];
    assign pop_idx  = sp_m1[IDXW-1:0];
    assign full_w   = (sp_q == SPW'(STACK_DEPTH));
    assign empty_w  = (sp_q == '0);

    // Clears are applied first so that an error event in the same cycle wins.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q & ~clr_err;
        unf_d   = unf_q & ~clr_err;
        push_en = 1'b0;
        if (ret) begin
            if (empty_w) begin
                unf_d = 1'b1;
            end else begin
                pc_d = stack_q[pop_idx];
                sp_d = sp_m1;
            end
        end else if (call) begin
            if (full_w) begin
                ovf_d = 1'b1;
            end else begin
                push_en = 1'b1;
                pc_d    = addr_in;
                sp_d    = sp_q + SPW'(1);
            end
        end else if (load) begin
            pc_d = addr_in;
        end else if (count) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_ADDR;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (push_en) begin
                stack_q[push_idx] <= pc_inc;
            end
        end
    end

    assign addr_out  = pc_q;
    assign sp        = sp_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, program address width in bits.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, number of return-address entries (legal range 2..16).
REQ-003 The block SHALL have parameter RESET_ADDR, default 0, program address loaded on reset.
REQ-004 The block SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-006 The block SHALL have port count  input  1  advance address by one.
REQ-007 The block SHALL have port load  input  1  jump to addr_in.
REQ-008 The block SHALL have port call  input  1  push return address, jump to addr_in.
REQ-009 The block SHALL have port ret  input  1  pop return address into program address.
REQ-010 The block SHALL have port clr_err  input  1  clear sticky overflow/underflow flags.
REQ-011 The block SHALL have port addr_in  input  ADDR_WIDTH  jump/call target.
REQ-012 The block SHALL have port addr_out  output  ADDR_WIDTH  current program address (registered).
REQ-013 The block SHALL have port sp  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
REQ-014 The block SHALL have port full  output  1  sp equals STACK_DEPTH.
REQ-015 The block SHALL have port empty  output  1  sp equals 0.
REQ-016 The block SHALL have port overflow  output  1  sticky: call attempted while full.
REQ-017 The block SHALL have port underflow  output  1  sticky: ret attempted while empty.

Function
REQ-018 The block SHALL resolve simultaneous commands by fixed priority ret > call > load > count; lower-priority commands in the same cycle are ignored.
REQ-019 On count alone, addr_out SHALL become addr_out+1 modulo 2^ADDR_WIDTH at the next rising edge (all-ones wraps to 0).
REQ-020 On load, addr_out SHALL become addr_in at the next rising edge; sp unchanged.
REQ-021 On call with full=0, entry[sp] SHALL receive (addr_out+1) modulo 2^ADDR_WIDTH, sp SHALL increment, and addr_out SHALL become addr_in, all in the same edge.
REQ-022 On call with full=1, addr_out, sp and stack contents SHALL hold and overflow SHALL set to 1.
REQ-023 On ret with empty=0, addr_out SHALL become entry[sp-1] and sp SHALL decrement in the same edge.
REQ-024 On ret with empty=1, addr_out and sp SHALL hold and underflow SHALL set to 1.
REQ-025 With no command asserted, addr_out, sp and stack SHALL hold.
REQ-026 full and empty SHALL be combinational decodes of registered sp; addr_out SHALL have one-cycle latency from command to new value.
REQ-027 clr_err SHALL clear overflow and underflow at the next edge; if an error event occurs in the same cycle, the flag SHALL be set (set wins).
REQ-028 Stack SHALL be LIFO; popped entries need not be cleared.
REQ-029 Command inputs SHALL be sampled only at rising clk; no combinational path from inputs to addr_out.

Reset
REQ-030 While rst=1, addr_out SHALL equal RESET_ADDR, sp SHALL be 0, overflow and underflow SHALL be 0, all stack entries SHALL be 0, asynchronously and regardless of clk.
REQ-031 Assertion of rst in the middle of a call/ret sequence SHALL discard the stack and all in-flight state; the first edge after rst deasserts SHALL act on the inputs as a normal cycle.

Verification
REQ-032 Bench SHALL check reset: rst=1 then release, no commands -> addr_out=0x00, sp=0, empty=1, full=0, flags 0.
REQ-033 Bench SHALL check count wrap: load 0xFE, count 3 cycles -> addr_out 0xFF, 0x00, 0x01.
REQ-034 Bench SHALL check nesting: at 0x10 call 0x40, at 0x40 call 0x80, ret, ret -> addr_out 0x40, 0x80, 0x41, 0x11; sp 1,2,1,0.
REQ-035 Bench SHALL check overflow: four calls (STACK_DEPTH=4) then a fifth call to 0x99 -> full=1, overflow=1, addr_out unchanged, sp=4; clr_err -> overflow=0.
REQ-036 Bench SHALL check underflow and priority: ret while empty -> underflow=1, addr_out held; ret+call+load+count together with sp=1 -> pop taken, sp=0, addr_in ignored.
REQ-037 Bench SHALL check async reset mid-operation: assert rst between clk edges after two calls -> addr_out=RESET_ADDR and sp=0 immediately, before the next edge.
